// File: rtl/imem_watch_pkg.sv
// Shared types and helpers for the instruction-memory watch monitor.
// Lane selection and strobe overlap assume a 32-bit bus word.
package imem_watch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EMPTY  = 2'd1,
      LOCKED = 2'd2
   } watch_state_t;

   localparam int WORD_W = 32;

   // Watched lane of a read word: halfword picked by addr bit 1, or the whole word.
   function automatic logic [WORD_W-1:0] lane_sel(
      input logic              lane,
      input logic [WORD_W-1:0] rdata,
      input int                gran
   );
      if (gran == 16) begin
         return lane ? {16'h0, rdata[31:16]} : {16'h0, rdata[15:0]};
      end
      return rdata;
   endfunction

   // True when the write strobes touch any byte of the watched granule.
   function automatic logic strb_overlap(
      input logic       lane,
      input logic [3:0] wstrb,
      input int         gran
   );
      if (gran == 16) begin
         return lane ? |wstrb[3:2] : |wstrb[1:0];
      end
      return |wstrb;
   endfunction

endpackage

// File: rtl/imem_watch_chan.sv
// One watch channel: arm/capture/compare state, fetch counter, mismatch flag.
// The top level decodes the handshake; this block only checks its own address.
module imem_watch_chan
   import imem_watch_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int GRAN           = 16,
   parameter int INVAL_ON_WRITE = 1,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              arm,
   input  logic [XLEN-1:0]   addr_in,
   input  logic              fetch_hs,
   input  logic              write_hs,
   input  logic [XLEN-1:0]   mem_addr,
   input  logic [XLEN/8-1:0] mem_wstrb,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              locked,
   output logic [GRAN-1:0]   data,
   output logic [CNT_W-1:0]  cnt,
   output logic              err
);

   watch_state_t     state_q;
   watch_state_t     state_d;
   logic [XLEN-1:0]  addr_q;
   logic [XLEN-1:0]  addr_m;
   logic [GRAN-1:0]  data_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic             hit;
   logic             fetch_hit;
   logic             write_hit;
   logic [WORD_W-1:0] lane_w;
   logic [GRAN-1:0]  lane;

   assign addr_m = {addr_in[XLEN-1:2], (GRAN == 16) ? addr_in[1] : 1'b0, 1'b0};

   assign hit       = addr_q[XLEN-1:2] == mem_addr[XLEN-1:2];
   assign fetch_hit = fetch_hs & hit;
   assign write_hit = write_hs & hit & (INVAL_ON_WRITE != 0)
                    & strb_overlap(addr_q[1], mem_wstrb[3:0], GRAN);

   assign lane_w = lane_sel(addr_q[1], mem_rdata[WORD_W-1:0], GRAN);
   assign lane   = lane_w[GRAN-1:0];

   // Channel state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state: arm wins, fetch locks an empty channel, overlapping write unlocks.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         EMPTY:   if (fetch_hit) state_d = LOCKED;
         LOCKED:  if (write_hit) state_d = EMPTY;
         default: state_d = IDLE;
      endcase
      if (arm) state_d = EMPTY;
   end

   // Address load, capture, compare and saturating fetch count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else if (arm) begin
         addr_q <= addr_m;
         data_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else if (fetch_hit && state_q != IDLE) begin
         if (state_q == EMPTY) data_q <= lane;
         if (state_q == LOCKED && lane != data_q) err_q <= 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign locked = state_q == LOCKED;
   assign data   = data_q;
   assign cnt    = cnt_q;
   assign err    = err_q;

endmodule

// File: rtl/imem_watch.sv
// Passive instruction-memory consistency monitor on the mem_* bus.
// Shared handshake decode, bus stability checker and the watch channels.
module imem_watch
   import imem_watch_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NUM_WATCH      = 4,
   parameter int GRAN           = 16,
   parameter int INVAL_ON_WRITE = 1,
   parameter int CNT_W          = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      mem_valid,
   input  logic                      mem_ready,
   input  logic                      mem_instr,
   input  logic [XLEN-1:0]           mem_addr,
   input  logic [XLEN/8-1:0]         mem_wstrb,
   input  logic [XLEN-1:0]           mem_rdata,
   input  logic                      arm,
   input  logic [NUM_WATCH*XLEN-1:0] watch_addr,
   output logic [NUM_WATCH-1:0]      locked,
   output logic [NUM_WATCH*GRAN-1:0] watch_data,
   output logic [NUM_WATCH*CNT_W-1:0] fetch_cnt,
   output logic [NUM_WATCH-1:0]      err_chan,
   output logic                      proto_err,
   output logic                      err
);

   logic              hs;
   logic              fetch_hs;
   logic              write_hs;
   logic              armed_q;
   logic              pend_q;
   logic [XLEN-1:0]   paddr_q;
   logic              pinstr_q;
   logic [XLEN/8-1:0] pwstrb_q;
   logic              perr_q;
   logic              unstable;
   logic              misalign;

   assign hs       = mem_valid & mem_ready;
   assign fetch_hs = hs & mem_instr & ~|mem_wstrb;
   assign write_hs = hs & |mem_wstrb;

   assign unstable = pend_q & (~mem_valid
                             | (mem_addr != paddr_q)
                             | (mem_instr != pinstr_q)
                             | (mem_wstrb != pwstrb_q));
   assign misalign = hs & |mem_addr[1:0];

   // Track the stalled request and raise sticky protocol errors once armed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_q  <= 1'b0;
         pend_q   <= 1'b0;
         paddr_q  <= '0;
         pinstr_q <= 1'b0;
         pwstrb_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         pend_q   <= mem_valid & ~mem_ready;
         paddr_q  <= mem_addr;
         pinstr_q <= mem_instr;
         pwstrb_q <= mem_wstrb;
         if (arm) begin
            armed_q <= 1'b1;
            perr_q  <= 1'b0;
         end else if (armed_q && (unstable || misalign)) begin
            perr_q  <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_WATCH; i++) begin : g_chan
      imem_watch_chan #(
         .XLEN           (XLEN),
         .GRAN           (GRAN),
         .INVAL_ON_WRITE (INVAL_ON_WRITE),
         .CNT_W          (CNT_W)
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .arm       (arm),
         .addr_in   (watch_addr[i*XLEN +: XLEN]),
         .fetch_hs  (fetch_hs),
         .write_hs  (write_hs),
         .mem_addr  (mem_addr),
         .mem_wstrb (mem_wstrb),
         .mem_rdata (mem_rdata),
         .locked    (locked[i]),
         .data      (watch_data[i*GRAN +: GRAN]),
         .cnt       (fetch_cnt[i*CNT_W +: CNT_W]),
         .err       (err_chan[i])
      );
   end

   assign proto_err = perr_q;
   assign err       = |err_chan | perr_q;

endmodule

// File: doc/imem_watch.md
Name: imem_watch

Overview:
- Bus-side instruction-memory consistency monitor for simulation and formal runs.
- Attaches passively to the core's mem_* valid/ready bus.
- Tracks NUM_WATCH independently armed addresses at GRAN-bit granularity. Each channel latches the first fetched value and flags any later fetch that returns different data.
- Adds three things a single-address checker lacks: write-invalidation, per-channel saturating fetch counters, and bus-protocol stability checking.

Parameters:
- XLEN, 32, address/data width.
- NUM_WATCH, 4, number of watch channels (1..16).
- GRAN, 16, watch granule in bits; 16 or 32 only.
- INVAL_ON_WRITE, 1, when 1 a write overlapping a locked granule returns that channel to EMPTY; when 0 writes are ignored.
- CNT_W, 16, width of each per-channel fetch counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  core request valid.
- mem_ready  in  1  memory ready; handshake = mem_valid & mem_ready at posedge clk.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  XLEN  request address.
- mem_wstrb  in  XLEN/8  write strobes; all-zero means read.
- mem_rdata  in  XLEN  read data, valid at handshake.
- arm  in  1  one-cycle pulse; loads watch_addr and arms all channels.
- watch_addr  in  NUM_WATCH*XLEN  watch addresses, sampled only on arm.
- locked  out  NUM_WATCH  channel holds a captured value.
- watch_data  out  NUM_WATCH*GRAN  captured value per channel.
- fetch_cnt  out  NUM_WATCH*CNT_W  fetch hits per channel since arm.
- err_chan  out  NUM_WATCH  sticky per-channel data-mismatch flag.
- proto_err  out  1  sticky handshake-stability or misalignment violation.
- err  out  1  combinational OR of err_chan and proto_err.

Behaviour:
- Reset (async, reset_n=0):
  - All channels go to IDLE.
  - All outputs and internal registers are 0.
  - Reset mid-transaction discards all state; no error is raised for the interrupted request.
- Per-channel states: IDLE, EMPTY, LOCKED. All state and outputs are registered and update at the posedge where the event is sampled.
- Hit test:
  - Word-address match: watch_addr[XLEN-1:2] == mem_addr[XLEN-1:2].
  - Lane selection: for GRAN=16, lane = stored watch_addr[1], taking rdata[15:0] or rdata[31:16]. For GRAN=32 the full word is used.
  - Stored watch_addr bits below GRAN/8 are masked to 0 on load.
- Transitions:
  - arm=1: every channel goes to EMPTY, addresses load, fetch_cnt, err_chan and proto_err clear, watch_data clears. arm takes priority over a same-cycle handshake, which is ignored.
  - Fetch hit (handshake, mem_instr=1, wstrb=0), from EMPTY: capture the lane into watch_data, move to LOCKED, cnt+1.
  - Fetch hit from LOCKED: compare the lane against watch_data. On mismatch set err_chan[i]; watch_data is unchanged. cnt+1 either way.
  - Write hit (handshake, wstrb!=0) whose strobe bits overlap the channel's granule: with INVAL_ON_WRITE=1, LOCKED goes to EMPTY and cnt is unchanged. With INVAL_ON_WRITE=0 there is no effect.
  - Data reads (mem_instr=0, wstrb=0) and all traffic in IDLE are ignored.
  - fetch_cnt saturates at 2^CNT_W-1; it does not wrap.
- Protocol check, active whenever not IDLE-all:
  - Once mem_valid=1 and mem_ready=0, mem_addr, mem_instr and mem_wstrb must stay stable, and mem_valid must stay 1, until the handshake. Any change sets proto_err at the next posedge.
  - A handshake with mem_addr[1:0]!=0 sets proto_err.
- Duplicate watch addresses are legal; the channels behave identically and independently.
- Sticky flags clear only on arm or reset.

Decomposition:
- Package imem_watch_pkg holds:
  - enum watch_state_t {IDLE, EMPTY, LOCKED};
  - a lane-select function (addr, rdata, GRAN) returning GRAN bits;
  - a strobe-overlap function.
- Sub-module imem_watch_chan: one channel covering state, capture, compare, counter and err flag, instantiated NUM_WATCH times by generate.
- The top level holds the shared handshake decode and the protocol checker.

Test Plan:
- Arm ch0=0x100 (GRAN=16). Fetch 0x100 returning 0xAAAA_1234 twice -> locked[0]=1, watch_data0=0x1234, fetch_cnt0=2, err=0.
- Arm ch1=0x102. Fetch 0x100 returning 0x5678_0000, then 0x9999_0000 -> watch_data1=0x5678, err_chan[1]=1 after the 2nd handshake, err=1; ch0 stays unaffected.
- INVAL_ON_WRITE=1, ch0 locked at 0x100. Write 0x100 wstrb=0b0011 -> locked[0]=0. Next fetch returns 0xBEEF -> relocked at 0xBEEF, no error. Repeat with wstrb=0b1100 -> ch0 stays locked.
- mem_valid=1, mem_ready=0, mem_addr changes 0x200 -> 0x204 next cycle -> proto_err=1. Separately, a handshake at mem_addr=0x201 -> proto_err=1.
- CNT_W=2. Five fetch hits -> fetch_cnt=3 (saturated). arm in the same cycle as a mismatching fetch -> err=0, cnt=0, state EMPTY.
- reset_n driven low asynchronously mid-stall with err set -> all outputs 0 immediately. After release, traffic is ignored until arm.
